ret_addr_ctrl: RTL
==================

# ret_addr_ctrl

Return-address controller for the accumulator processor's subroutine mechanism. Sits directly upstream of the parameterized `stack` block: it takes one-cycle call/return requests from the instruction decoder, drives the stack's `en`/`ctrl`/`data_in`/`clr` pins, and captures the stack's registered `data_out` into a return address with a valid pulse. It keeps its own occupancy count, so the stack is never pushed when full or popped when empty, and overflow/underflow are reported to the controller.

## Interface
- `WIDTH`, 8: address/data width; matches the stack `width`.
- `DEPTH`, 2: log2 of the stack capacity; matches the stack `depth`. Capacity `CAP = 2**DEPTH`.

- `clk`  in  1  clock; all logic on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `call`  in  1  push request; sampled only in IDLE.
- `ret`  in  1  pop request; sampled only in IDLE.
- `pc_in`  in  WIDTH  return address to save, sampled with `call`.
- `stk_q`  in  WIDTH  stack `data_out`.
- `stk_en`  out  1  stack `en`.
- `stk_ctrl`  out  1  stack `ctrl`: 0 = push, 1 = pop.
- `stk_data`  out  WIDTH  stack `data_in`.
- `stk_clr_n`  out  1  stack `clr` (active-low). Combinational `~clr`.
- `ret_addr`  out  WIDTH  last popped address; holds until the next successful return.
- `ret_valid`  out  1  one-cycle pulse when `ret_addr` is updated.
- `busy`  out  1  high whenever state is not IDLE.
- `count`  out  DEPTH+1  current stack occupancy, 0..CAP.
- `overflow`  out  1  sticky: a call was issued with `count == CAP`.
- `underflow`  out  1  sticky: a return was issued with `count == 0`.

## Operation
- States: IDLE, PUSH, POP, WAIT, DONE. `stk_en`, `stk_ctrl`, `ret_valid` and `busy` decode from the state register only.
- IDLE: `stk_en = 0`.
  - `call & ~ret`, `count < CAP`: latch `pc_in` into `stk_data`, `count += 1`, go to PUSH.
  - `call & ~ret`, `count == CAP`: set `overflow`, stay in IDLE, no stack access.
  - `ret & ~call`, `count > 0`: `count -= 1`, go to POP.
  - `ret & ~call`, `count == 0`: set `underflow`, stay in IDLE.
  - `call & ret` together: both ignored. No flags set, no state change.
- PUSH: `stk_en = 1`, `stk_ctrl = 0`, `stk_data` stable. Next state IDLE.
- POP: `stk_en = 1`, `stk_ctrl = 1`. Next state WAIT.
- WAIT: `stk_en = 0`. At the end of this cycle, capture `stk_q` into `ret_addr`. Next state DONE.
- DONE: `ret_valid = 1`. Next state IDLE.
- `call`/`ret` are ignored while `busy`. The decoder must not issue requests while `busy` is high.
- `count` never wraps. Its bounds are enforced by the overflow/underflow checks, so the stack's own full/empty flags are never exercised.
- Reset (`clr = 1`), including mid-operation:
  - state goes to IDLE, `count`, `stk_data`, `ret_addr`, `overflow`, `underflow` go to 0;
  - `stk_en`, `stk_ctrl`, `ret_valid`, `busy` are 0 from the next cycle;
  - `stk_clr_n` is 0 in the same cycle, so the stack clears on the same edge.
- `overflow` and `underflow` are cleared only by `clr`.

## Timing
- Call sampled at edge N:
  - PUSH during cycle N+1; the stack writes at edge N+2.
  - `count` is updated from cycle N+1.
  - `busy` is high for 1 cycle; the next request can be sampled at edge N+2.
- Return sampled at edge N:
  - POP during N+1; the stack pops at edge N+2, and `stk_q` is valid during N+2.
  - `ret_addr` is captured at edge N+3.
  - `ret_valid` is high during N+3 only.
  - `busy` is high during N+1..N+3; the next request can be sampled at edge N+4.
  - Return latency from request to `ret_valid` is 3 cycles.
- Flags set at edge N are visible from cycle N+1.

## Test plan
- Reset, then check idle outputs: hold `clr` 2 cycles -> all outputs 0, `stk_clr_n = 0` during `clr`, 1 after.
- Call then return: call `pc_in = 0x3A` -> `stk_en = 1`, `stk_ctrl = 0`, `stk_data = 0x3A` for one cycle, `count = 1`. Then ret -> `ret_valid` pulses 3 cycles after the request with `ret_addr = 0x3A`, `count = 0`.
- Fill and overflow (DEPTH = 2): calls with 0x10, 0x11, 0x12, 0x13 -> `count = 4`. A 5th call with 0x14 -> `overflow = 1`, no `stk_en`, `count` stays 4. Four returns -> `ret_addr` sequence 0x13, 0x12, 0x11, 0x10.
- Underflow: ret with `count = 0` -> `underflow = 1`, no `stk_en`, no `ret_valid`. A later valid call/ret pair still works, and `underflow` stays 1.
- Conflicting and busy-time requests:
  - `call` and `ret` in the same IDLE cycle -> no stack activity, no flags.
  - `call` asserted during WAIT -> ignored, `count` unchanged.
- Reset mid-return: assert `clr` during WAIT -> next cycle IDLE, `ret_valid` never pulses, `ret_addr = 0`, `count = 0`, stack cleared.

Source files
------------

// File: rtl/ret_addr_ctrl.sv
// ret_addr_ctrl -- return-address controller for the subroutine stack.
//
// Takes one-cycle call/return requests from the decoder and drives the
// downstream stack (en/ctrl/data_in/clr). Pops are captured from the stack's
// registered data_out into ret_addr, and a one-cycle ret_valid pulse marks the
// update. An internal occupancy count keeps the stack from being pushed when
// full or popped when empty. Those cases raise sticky overflow/underflow flags.
//
// Handshake: call/ret are sampled only while busy is low. A request that is
// seen in IDLE is acted on at that edge. Requests seen while busy are dropped.
// A cycle with call and ret both high is a no-op.
//
// Ports:
//   clk        clock, rising edge
//   clr        synchronous active-high reset
//   call, ret  push / pop requests (sampled in IDLE only)
//   pc_in      return address to save with call
//   stk_q      stack data_out (registered inside the stack)
//   stk_en     stack enable
//   stk_ctrl   stack op: 0 = push, 1 = pop
//   stk_data   stack data_in
//   stk_clr_n  stack clear, active-low, combinational ~clr
//   ret_addr   last popped address
//   ret_valid  one-cycle pulse when ret_addr updates
//   busy       high whenever the FSM is not IDLE
//   count      stack occupancy, 0..2**DEPTH
//   overflow   sticky: call issued while full
//   underflow  sticky: return issued while empty
module ret_addr_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] stk_q,
  output logic             stk_en,
  output logic             stk_ctrl,
  output logic [WIDTH-1:0] stk_data,
  output logic             stk_clr_n,
  output logic [WIDTH-1:0] ret_addr,
  output logic             ret_valid,
  output logic             busy,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int CAP = 2 ** DEPTH;
  localparam logic [DEPTH:0] CAP_CNT = (DEPTH + 1)'(CAP);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_POP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic do_push;
  logic do_pop;
  logic do_ovf;
  logic do_unf;

  // Request decode and next state. Simultaneous call and ret match neither
  // branch, so they leave everything unchanged.
  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_ovf    = 1'b0;
    do_unf    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (call && !ret) begin
          if (count < CAP_CNT) begin
            do_push   = 1'b1;
            state_nxt = ST_PUSH;
          end else begin
            do_ovf = 1'b1;
          end
        end else if (ret && !call) begin
          if (count != '0) begin
            do_pop    = 1'b1;
            state_nxt = ST_POP;
          end else begin
            do_unf = 1'b1;
          end
        end
      end
      ST_PUSH: state_nxt = ST_IDLE;
      ST_POP:  state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      count     <= '0;
      stk_data  <= '0;
      ret_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_push) begin
        stk_data <= pc_in;
        count    <= count + 1'b1;
      end
      if (do_pop) begin
        count <= count - 1'b1;
      end
      if (do_ovf) begin
        overflow <= 1'b1;
      end
      if (do_unf) begin
        underflow <= 1'b1;
      end
      // The stack popped at the end of POP, so its data_out is valid in WAIT.
      if (state == ST_WAIT) begin
        ret_addr <= stk_q;
      end
    end
  end

  // Stack controls and status decode only from the state register.
  assign stk_en    = (state == ST_PUSH) || (state == ST_POP);
  assign stk_ctrl  = (state == ST_POP);
  assign ret_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  // The stack clear is combinational, so the stack clears on the same edge.
  assign stk_clr_n = ~clr;

endmodule
